// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector: channel mode encodings
// and debounce counter sizing.
package edge_det_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Counter must hold values up to DEBOUNCE_CYCLES-1; keep at least one bit
  function automatic int cnt_width(input int unsigned debounce_cycles);
    return (debounce_cycles < 2) ? 1 : $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/edge_channel.sv
// One input channel: synchroniser chain, debounce counter, accepted level,
// mode-qualified edge pulse and sticky write-1-to-clear event flag.
module edge_channel
  import edge_det_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       signal,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level,
  output logic       edge_pulse,
  output logic       event_flag
);

  localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;
  logic                   differ;
  logic                   accept;
  logic                   mode_hit;

  assign s      = sync[SYNC_STAGES-1];
  assign differ = s ^ level;
  assign accept = differ && (cnt == CNT_LAST);

  // s is the level about to be accepted, so s=1 means a rising toggle
  always_comb begin
    mode_hit = 1'b0;
    case (mode)
      MODE_OFF:  mode_hit = 1'b0;
      MODE_RISE: mode_hit = s;
      MODE_FALL: mode_hit = ~s;
      MODE_BOTH: mode_hit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync       <= '0;
      cnt        <= '0;
      level      <= 1'b0;
      edge_pulse <= 1'b0;
      event_flag <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], signal};
      event_flag <= edge_pulse | (event_flag & ~clr);
      edge_pulse <= accept & mode_hit;
      if (!differ || accept) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (accept) begin
        level <= s;
      end
    end
  end

endmodule

// File: rtl/edge_detector_multi.sv
// N-channel synchronising, debouncing edge detector with sticky events and a
// summary interrupt. Per-channel logic lives in edge_channel.
module edge_detector_multi #(
  parameter int unsigned CHANNELS        = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   signal,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clr,
  input  logic [CHANNELS-1:0]   irq_en,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   edge_pulse,
  output logic [CHANNELS-1:0]   event_flag,
  output logic                  irq
);

  // event_flag carries the sticky event bits ('event' is a reserved word)
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .signal    (signal[i]),
      .mode      (mode[2*i +: 2]),
      .clr       (clr[i]),
      .level     (level[i]),
      .edge_pulse(edge_pulse[i]),
      .event_flag(event_flag[i])
    );
  end

  // Built only from registered events and irq_en, so the signal path cannot glitch it
  assign irq = |(event_flag & irq_en);

endmodule

// File: tb/tb_edge_detector_multi.sv
// Bench for edge_detector_multi: two instances (debounce 1 and 4) driven in parallel,
// checked every cycle against a window-based model plus directed literal checks.
module tb_edge_detector_multi;

  localparam int unsigned NCH  = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned HD   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   signal;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0]   clr;
  logic [NCH-1:0]   irq_en;
  logic [NCH-1:0]   level0, pulse0, event0;
  logic [NCH-1:0]   level4, pulse4, event4;
  logic             irq0, irq4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edge_detector_multi #(.CHANNELS(NCH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .signal(signal), .mode(mode), .clr(clr), .irq_en(irq_en),
    .level(level0), .edge_pulse(pulse0), .event_flag(event0), .irq(irq0)
  );

  edge_detector_multi #(.CHANNELS(NCH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .signal(signal), .mode(mode), .clr(clr), .irq_en(irq_en),
    .level(level4), .edge_pulse(pulse4), .event_flag(event4), .irq(irq4)
  );

  // Model: raw input history per channel; the level flips once the synchronised
  // samples of the last DEBOUNCE_CYCLES edges all disagree with it.
  logic m_raw   [2][NCH][HD];
  logic m_level [2][NCH];
  logic m_pulse [2][NCH];
  logic m_event [2][NCH];
  logic m_flip;

  function automatic int deb(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NCH; c++) begin
          m_level[d][c] = 1'b0;
          m_pulse[d][c] = 1'b0;
          m_event[d][c] = 1'b0;
          for (int k = 0; k < HD; k++) m_raw[d][c][k] = 1'b0;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NCH; c++) begin
          for (int k = HD - 1; k > 0; k--) m_raw[d][c][k] = m_raw[d][c][k-1];
          m_raw[d][c][0] = signal[c];
          m_flip = 1'b1;
          for (int k = 0; k < deb(d); k++) begin
            if (m_raw[d][c][SYNC + k] == m_level[d][c]) m_flip = 1'b0;
          end
          m_event[d][c] = m_pulse[d][c] | (m_event[d][c] & ~clr[c]);
          m_pulse[d][c] = m_flip & (m_level[d][c] ? mode[2*c+1] : mode[2*c]);
          if (m_flip) m_level[d][c] = ~m_level[d][c];
        end
      end
    end
  end

  function automatic logic [NCH-1:0] mvec(input int d, input int w);
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) begin
      case (w)
        0:       v[c] = m_level[d][c];
        1:       v[c] = m_pulse[d][c];
        default: v[c] = m_event[d][c];
      endcase
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("model level d1", 32'(level0), 32'(mvec(0, 0)));
      chk("model pulse d1", 32'(pulse0), 32'(mvec(0, 1)));
      chk("model event d1", 32'(event0), 32'(mvec(0, 2)));
      chk("model irq d1",   32'(irq0),   32'(|(mvec(0, 2) & irq_en)));
      chk("model level d4", 32'(level4), 32'(mvec(1, 0)));
      chk("model pulse d4", 32'(pulse4), 32'(mvec(1, 1)));
      chk("model event d4", 32'(event4), 32'(mvec(1, 2)));
      chk("model irq d4",   32'(irq4),   32'(|(mvec(1, 2) & irq_en)));
    end
  end

  // Advance to just after the n-th following falling edge
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int pc;
    int fc;
    int oc;
    bit seen;

    rst    = 1'b0;
    signal = '0;
    mode   = 16'h00F5;   // ch0/ch1 rise, ch2/ch3 both, others off
    clr    = '0;
    irq_en = '0;
    #7;
    chk("reset outputs d1", 32'({level0, pulse0, event0}), 32'h0);
    chk("reset outputs d4", 32'({level4, pulse4, event4}), 32'h0);
    chk("reset irq", 32'({irq0, irq4}), 32'h0);
    step(2);
    rst = 1'b1;
    step(3);

    // Latency: input rises before edge 0
    signal[0] = 1'b1;
    step(1); chk("t1 pulse edge0", 32'(pulse0[0]), 32'h0);
    step(1); chk("t1 pulse edge1", 32'(pulse0[0]), 32'h0);
    step(1); chk("t1 pulse edge2", 32'(pulse0[0]), 32'h1);
             chk("t1 level edge2", 32'(level0[0]), 32'h1);
    step(1); chk("t1 pulse edge3", 32'(pulse0[0]), 32'h0);
             chk("t1 d4 pulse edge3", 32'(pulse4[0]), 32'h0);
    step(1); chk("t1 d4 pulse edge4", 32'(pulse4[0]), 32'h0);
    step(1); chk("t1 d4 pulse edge5", 32'(pulse4[0]), 32'h1);
             chk("t1 d4 level edge5", 32'(level4[0]), 32'h1);

    // Debounce 4: 3-cycle glitch rejected, 4-cycle high accepted
    pc = 0;
    signal[1] = 1'b1;
    repeat (3) begin step(1); pc += int'(pulse4[1]); end
    signal[1] = 1'b0;
    repeat (10) begin step(1); pc += int'(pulse4[1]); end
    chk("t2 glitch pulses", 32'(pc), 32'h0);
    chk("t2 glitch level", 32'(level4[1]), 32'h0);
    pc = 0;
    signal[1] = 1'b1;
    repeat (4) begin step(1); pc += int'(pulse4[1]); end
    signal[1] = 1'b0;
    repeat (10) begin step(1); pc += int'(pulse4[1]); end
    chk("t2 accepted pulses", 32'(pc), 32'h1);

    // Both-edge mode, then fall-only; ch4 (off) toggles alongside
    pc = 0; oc = 0;
    signal[2] = 1'b1; signal[4] = 1'b1;
    repeat (10) begin step(1); pc += int'(pulse0[2]); oc += int'(pulse0[4]); end
    chk("t3 off level tracks", 32'(level0[4]), 32'h1);
    signal[2] = 1'b0; signal[4] = 1'b0;
    repeat (10) begin step(1); pc += int'(pulse0[2]); oc += int'(pulse0[4]); end
    chk("t3 both pulses", 32'(pc), 32'h2);
    chk("t3 event", 32'(event0[2]), 32'h1);
    chk("t3 off pulses", 32'(oc), 32'h0);
    mode[5:4] = 2'b10;
    pc = 0; fc = 0;
    signal[2] = 1'b1;
    repeat (10) begin step(1); pc += int'(pulse0[2]); fc += int'(pulse0[2] & ~level0[2]); end
    signal[2] = 1'b0;
    repeat (10) begin step(1); pc += int'(pulse0[2]); fc += int'(pulse0[2] & ~level0[2]); end
    chk("t3 fall-only pulses", 32'(pc), 32'h1);
    chk("t3 fall-only falling", 32'(fc), 32'h1);

    // Set wins over simultaneous clear, clear alone then drops the flag
    signal[3] = 1'b1;
    step(6);
    chk("t4 event set", 32'(event0[3]), 32'h1);
    signal[3] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1);
      if (pulse0[3]) seen = 1'b1;
    end
    chk("t4 fall pulse seen", 32'(seen), 32'h1);
    if (seen) begin
      clr[3] = 1'b1;
      step(1); chk("t4 set wins", 32'(event0[3]), 32'h1);
      step(1); chk("t4 clear", 32'(event0[3]), 32'h0);
    end
    clr = '0;

    // Interrupt masking
    clr = '1;
    step(8);
    clr = '0;
    signal[1] = 1'b1;
    step(4);
    chk("t5 events", 32'(event0), 32'h02);
    irq_en = 8'h01;
    #1; chk("t5 irq masked", 32'(irq0), 32'h0);
    irq_en = 8'h03;
    #1; chk("t5 irq enabled", 32'(irq0), 32'h1);

    // Reset mid-debounce with input high
    signal = '0;
    irq_en = '0;
    step(8);
    signal[0] = 1'b1;
    step(2);
    #2;
    rst = 1'b0;
    #1;
    chk("t6 rst outputs d1", 32'({level0, pulse0, event0}), 32'h0);
    chk("t6 rst outputs d4", 32'({level4, pulse4, event4}), 32'h0);
    chk("t6 rst irq", 32'({irq0, irq4}), 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    step(1); chk("t6 pulse edge0", 32'(pulse0[0]), 32'h0);
             chk("t6 level edge0", 32'(level0[0]), 32'h0);
    step(1); chk("t6 pulse edge1", 32'(pulse0[0]), 32'h0);
    step(1); chk("t6 pulse edge2", 32'(pulse0[0]), 32'h1);
             chk("t6 level edge2", 32'(level0[0]), 32'h1);
    step(1); chk("t6 pulse edge3", 32'(pulse0[0]), 32'h0);
    step(1); chk("t6 d4 pulse edge4", 32'(pulse4[0]), 32'h0);
    step(1); chk("t6 d4 pulse edge5", 32'(pulse4[0]), 32'h1);

    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
